// File: rtl/instr_sched.sv
// instr_sched: fetches tagged descriptor words, issues them to the datapath, counts layers; INSTR_SCHED_PERF_EN adds an ISSUE+RUN cycle counter.
module instr_sched #(
    parameter int AXIS_DATA_WIDTH = 64,
    parameter int INSTR_WORDS     = 8
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [31:0]                            scalar,
    input  logic                                   s_axis_instr_tvalid,
    output logic                                   s_axis_instr_tready,
    input  logic [AXIS_DATA_WIDTH-1:0]             s_axis_instr_tdata,
    output logic                                   cfg_valid,
    input  logic                                   cfg_ready,
    output logic [AXIS_DATA_WIDTH*INSTR_WORDS-1:0] cfg_data,
    input  logic                                   layer_done,
    output logic [1:0][31:0]                       status
);
    localparam int IW = $clog2(INSTR_WORDS);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] ISSUE = 3'd2;
    localparam logic [2:0] RUN   = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
    localparam logic [2:0] ERR   = 3'd5;
    logic [2:0]    state;
    logic [IW-1:0] idx;
    logic [31:0]   count;
    logic [31:0]   count_nx;
    logic [15:0]   perf;
    logic          accept;
    logic          tag_ok;
    logic          last;
    logic          fetch_done;
    assign accept     = s_axis_instr_tvalid && state == FETCH;
    assign tag_ok     = s_axis_instr_tdata[AXIS_DATA_WIDTH-1 -: 4] == 4'(4'h8 + 4'(idx));
    assign last       = idx == IW'(INSTR_WORDS - 1);
    assign fetch_done = accept && tag_ok && last;
    assign count_nx   = count + 32'd1;
    assign s_axis_instr_tready = state == FETCH;
    assign cfg_valid  = state == ISSUE;
    assign status[0]  = count;
    assign status[1]  = {perf, 8'h00, 3'(idx), state == DONE, state == ERR, state};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            count    <= '0;
            cfg_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state <= FETCH;
                    idx   <= '0;
                end
                FETCH: if (accept) begin
                    if (!tag_ok) state <= ERR;
                    else begin
                        cfg_data[idx*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH] <= s_axis_instr_tdata;
                        idx   <= last ? '0 : idx + 1'b1;
                        state <= last ? ISSUE : FETCH;
                    end
                end
                ISSUE: if (cfg_ready) state <= RUN;
                RUN: if (layer_done) begin
                    count <= count_nx;
                    idx   <= '0;
                    state <= (scalar != 32'd0 && count_nx == scalar) ? DONE : FETCH;
                end
                default: ;
            endcase
        end
    end
`ifdef INSTR_SCHED_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) perf <= '0;
        else if (fetch_done) perf <= '0;
        else if ((state == ISSUE || state == RUN) && perf != 16'hFFFF) perf <= perf + 16'd1;
    end
`else
    assign perf = '0;
`endif
endmodule

// File: tb/tb_instr_sched.sv
// tb_instr_sched: scoreboard bench for instr_sched; expected descriptors are queued at send and compared on the cfg handshake.
module tb_instr_sched;
    logic               clk = 0;
    logic               rst_n = 0;
    logic [31:0]        scalar = 0;
    logic               s_tvalid = 0;
    logic               s_tready;
    logic [63:0]        s_tdata = 0;
    logic               cfg_valid;
    logic               cfg_ready = 0;
    logic [511:0]       cfg_data;
    logic               layer_done = 0;
    logic [1:0][31:0]   status;
    int                 n_checks = 0;
    int                 n_fail = 0;
    logic [511:0]       exp_q[$];
    logic [511:0]       last_desc;
    logic               hold = 0;
    logic [511:0]       held = 0;
    instr_sched dut (
        .clk(clk), .rst_n(rst_n), .scalar(scalar),
        .s_axis_instr_tvalid(s_tvalid), .s_axis_instr_tready(s_tready), .s_axis_instr_tdata(s_tdata),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
        .layer_done(layer_done), .status(status)
    );
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (!rst_n) hold <= 0;
        else begin
            if (hold && cfg_valid) begin
                n_checks++;
                if (cfg_data !== held) begin n_fail++; $display("FAIL stable: cfg_data=%h held=%h", cfg_data, held); end
            end
            if (cfg_valid && cfg_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL scoreboard: unexpected handshake data=%h", cfg_data); end
                else if (cfg_data !== exp_q[0]) begin n_fail++; $display("FAIL scoreboard: got %h want %h", cfg_data, exp_q[0]); void'(exp_q.pop_front()); end
                else void'(exp_q.pop_front());
            end
            hold <= cfg_valid && !cfg_ready;
            held <= cfg_data;
        end
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    task automatic do_reset();
        rst_n = 0; cfg_ready = 0; s_tvalid = 0; layer_done = 0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;
    endtask
    task automatic send_word(input logic [63:0] w, input int gap);
        bit ok = 0;
        s_tvalid = 0;
        repeat (gap) begin @(posedge clk); #1; end
        s_tvalid = 1; s_tdata = w;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (s_tready) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: tready=%b want 1", s_tready);
        end else begin
            @(posedge clk); #1;
        end
        s_tvalid = 0;
    endtask
    task automatic send_layer(input bit rnd);
        logic [511:0] d;
        logic [63:0]  w;
        for (int i = 0; i < 8; i++) begin
            w = {$urandom, $urandom};
            w[63:60] = 4'(8 + i);
            d[64*i +: 64] = w;
        end
        exp_q.push_back(d);
        last_desc = d;
        for (int i = 0; i < 8; i++) send_word(d[64*i +: 64], rnd ? $urandom_range(0, 2) : 0);
    endtask
    task automatic handshake(input int delay);
        cfg_ready = 0;
        repeat (delay) begin @(posedge clk); #1; end
        cfg_ready = 1;
        @(posedge clk); #1;
        cfg_ready = 0;
    endtask
    task automatic pulse_done(input int after);
        repeat (after - 1) begin @(posedge clk); #1; end
        layer_done = 1;
        @(posedge clk); #1;
        layer_done = 0;
    endtask
    task automatic test_reset();
        rst_n = 0;
        @(negedge clk);
        n_checks++;
        if ({s_tready, cfg_valid} !== 2'b00 || cfg_data !== '0 || status !== '0) begin
            n_fail++; $display("FAIL reset_outputs: tready=%b cfg_valid=%b status=%h", s_tready, cfg_valid, status);
        end
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk);
        n_checks++;
        if (status[1] !== 32'd0) begin n_fail++; $display("FAIL reset_idle: status1=%h want 0", status[1]); end
        @(negedge clk);
        n_checks++;
        if (status[1][2:0] !== 3'd1 || s_tready !== 1'b1) begin
            n_fail++; $display("FAIL reset_fetch: state=%0d tready=%b want 1/1", status[1][2:0], s_tready);
        end
    endtask
    task automatic test_single();
        int hi = 0;
        do_reset(); scalar = 1;
        send_layer(0);
        n_checks++;
        if (cfg_valid !== 1'b1 || s_tready !== 1'b0) begin
            n_fail++; $display("FAIL single_issue: cfg_valid=%b tready=%b want 1/0", cfg_valid, s_tready);
        end
        handshake(0);
        pulse_done(5);
        n_checks++;
        if (status[0] !== 32'd1 || status[1][2:0] !== 3'd4 || status[1][4] !== 1'b1) begin
            n_fail++; $display("FAIL single_done: count=%0d state=%0d want 1/4", status[0], status[1][2:0]);
        end
        s_tvalid = 1;
        repeat (5) begin @(negedge clk); hi += (s_tready || cfg_valid) ? 1 : 0; end
        s_tvalid = 0;
        n_checks++;
        if (hi != 0 || status[1][2:0] !== 3'd4) begin
            n_fail++; $display("FAIL done_sticky: busy_cycles=%0d state=%0d want 0/4", hi, status[1][2:0]);
        end
    endtask
    task automatic test_back_to_back();
        do_reset(); scalar = 8;
        for (int l = 0; l < 8; l++) begin
            send_layer(1);
            handshake($urandom_range(0, 3));
            pulse_done($urandom_range(1, 4));
            n_checks++;
            if (status[0] !== 32'(l + 1) || status[1][2:0] !== (l == 7 ? 3'd4 : 3'd1)) begin
                n_fail++; $display("FAIL b2b_layer%0d: count=%0d state=%0d", l, status[0], status[1][2:0]);
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_drain: pending=%0d want 0", exp_q.size()); end
    endtask
    task automatic test_tag_err();
        int v = 0;
        do_reset(); scalar = 0;
        for (int i = 0; i < 3; i++) send_word({4'(8 + i), 60'h123_4567_89AB_CDEF}, 0);
        send_word({4'hC, 60'hFFF_FFFF_FFFF_FFFF}, 0);
        n_checks++;
        if (status[1][2:0] !== 3'd5 || status[1][3] !== 1'b1 || s_tready !== 1'b0) begin
            n_fail++; $display("FAIL tag_err: state=%0d err=%b tready=%b want 5/1/0", status[1][2:0], status[1][3], s_tready);
        end
        n_checks++;
        if (cfg_data[255:192] !== 64'd0) begin n_fail++; $display("FAIL tag_discard: slot3=%h want 0", cfg_data[255:192]); end
        repeat (6) begin @(negedge clk); v += cfg_valid ? 1 : 0; end
        n_checks++;
        if (v != 0) begin n_fail++; $display("FAIL err_no_valid: valid_cycles=%0d want 0", v); end
    endtask
    task automatic test_unbounded();
        do_reset(); scalar = 0;
        for (int l = 0; l < 3; l++) begin send_layer(0); handshake(1); pulse_done(2); end
        n_checks++;
        if (status[0] !== 32'd3 || status[1][2:0] !== 3'd1 || s_tready !== 1'b1) begin
            n_fail++; $display("FAIL unbounded: count=%0d state=%0d tready=%b want 3/1/1", status[0], status[1][2:0], s_tready);
        end
        pulse_done(1);
        n_checks++;
        if (status[0] !== 32'd3) begin n_fail++; $display("FAIL done_ignored: count=%0d want 3", status[0]); end
        send_word({4'h8, 60'hA}, 0);
        send_word({4'h9, 60'hB}, 0);
        n_checks++;
        if (cfg_data[511:128] !== last_desc[511:128] || cfg_data[127:0] !== {4'h9, 60'hB, 4'h8, 60'hA}) begin
            n_fail++; $display("FAIL slot_retain: got %h want %h", cfg_data[511:128], last_desc[511:128]);
        end
    endtask
    task automatic test_scalar_reduce();
        do_reset(); scalar = 5;
        for (int l = 0; l < 2; l++) begin send_layer(0); handshake(0); pulse_done(1); end
        scalar = 1;
        send_layer(0); handshake(0); pulse_done(1);
        n_checks++;
        if (status[0] !== 32'd3 || status[1][2:0] !== 3'd1) begin
            n_fail++; $display("FAIL scalar_below: count=%0d state=%0d want 3/1", status[0], status[1][2:0]);
        end
        scalar = 4;
        send_layer(0); handshake(0); pulse_done(1);
        n_checks++;
        if (status[0] !== 32'd4 || status[1][2:0] !== 3'd4) begin
            n_fail++; $display("FAIL scalar_raise: count=%0d state=%0d want 4/4", status[0], status[1][2:0]);
        end
    endtask
    task automatic test_reset_run();
        do_reset(); scalar = 0;
        send_layer(0); handshake(0);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 0;
        layer_done = 1;
        @(negedge clk);
        n_checks++;
        if ({s_tready, cfg_valid} !== 2'b00 || cfg_data !== '0 || status !== '0) begin
            n_fail++; $display("FAIL reset_run: tready=%b cfg_valid=%b status=%h", s_tready, cfg_valid, status);
        end
        @(posedge clk); #1 layer_done = 0; rst_n = 1;
        @(posedge clk); #1;
        send_layer(0); handshake(0);
        n_checks++;
        if (status[0] !== 32'd0 || status[1][2:0] !== 3'd3) begin
            n_fail++; $display("FAIL reset_resume: count=%0d state=%0d want 0/3", status[0], status[1][2:0]);
        end
    endtask
    task automatic test_perf();
        logic [15:0] want;
`ifdef INSTR_SCHED_PERF_EN
        want = 16'd13;
`else
        want = 16'd0;
`endif
        do_reset(); scalar = 1;
        send_layer(0); handshake(2); pulse_done(10);
        n_checks++;
        if (status[1][31:16] !== want || status[1][2:0] !== 3'd4) begin
            n_fail++; $display("FAIL perf: cycles=%0d want %0d", status[1][31:16], want);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (status[1][31:16] !== want) begin n_fail++; $display("FAIL perf_hold: cycles=%0d want %0d", status[1][31:16], want); end
    endtask
    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_tag_err();
        test_unbounded();
        test_scalar_reduce();
        test_reset_run();
        test_perf();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
